// File: rtl/mult_pkg.sv
// Shared widths and types for the 4x4 unsigned array multiplier.
package mult_pkg;
  localparam int MULT_W = 4;
  localparam int PROD_W = 8;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/multiplier_4bit_full_adder.sv
// One-bit full adder from gate equations; used with cin tied low as a half adder.
// Latency: combinational; no backpressure.
module full_adder
  import mult_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multiplier_4bit.sv
// Unsigned 4x4 array multiplier: combinational P plus a registered copy P_q.
// Latency: P 0 cycles, P_q 1 cycle; no backpressure, a new product is accepted every cycle.
module multiplier_4bit
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic [7:0] P_q,
  output logic       p_valid
);
  // pp[i][j] = A[j] & B[i]: row i is the multiplicand gated by multiplier bit i.
  operand_t pp [MULT_W];

  for (genvar i = 0; i < MULT_W; i++) begin : g_pp_row
    for (genvar j = 0; j < MULT_W; j++) begin : g_pp_bit
      assign pp[i][j] = A[j] & B[i];
    end
  end

  logic s1_0, s1_1, s1_2, s1_3, c1_0, c1_1, c1_2, c1_3;
  logic s2_0, s2_1, s2_2, s2_3, c2_0, c2_1, c2_2, c2_3;
  logic s3_0, s3_1, s3_2, s3_3, c3_0, c3_1, c3_2, c3_3;

  // Row 1: pp row 1 against pp row 0 shifted down one place.
  full_adder u_r1_c0 (.a(pp[1][0]), .b(pp[0][1]), .cin(1'b0), .sum(s1_0), .cout(c1_0));
  full_adder u_r1_c1 (.a(pp[1][1]), .b(pp[0][2]), .cin(c1_0), .sum(s1_1), .cout(c1_1));
  full_adder u_r1_c2 (.a(pp[1][2]), .b(pp[0][3]), .cin(c1_1), .sum(s1_2), .cout(c1_2));
  full_adder u_r1_c3 (.a(pp[1][3]), .b(1'b0),     .cin(c1_2), .sum(s1_3), .cout(c1_3));

  // Each later row takes the upper three sums and carry-out of the row above.
  full_adder u_r2_c0 (.a(pp[2][0]), .b(s1_1), .cin(1'b0), .sum(s2_0), .cout(c2_0));
  full_adder u_r2_c1 (.a(pp[2][1]), .b(s1_2), .cin(c2_0), .sum(s2_1), .cout(c2_1));
  full_adder u_r2_c2 (.a(pp[2][2]), .b(s1_3), .cin(c2_1), .sum(s2_2), .cout(c2_2));
  full_adder u_r2_c3 (.a(pp[2][3]), .b(c1_3), .cin(c2_2), .sum(s2_3), .cout(c2_3));

  full_adder u_r3_c0 (.a(pp[3][0]), .b(s2_1), .cin(1'b0), .sum(s3_0), .cout(c3_0));
  full_adder u_r3_c1 (.a(pp[3][1]), .b(s2_2), .cin(c3_0), .sum(s3_1), .cout(c3_1));
  full_adder u_r3_c2 (.a(pp[3][2]), .b(s2_3), .cin(c3_1), .sum(s3_2), .cout(c3_2));
  full_adder u_r3_c3 (.a(pp[3][3]), .b(c2_3), .cin(c3_2), .sum(s3_3), .cout(c3_3));

  assign P = {c3_3, s3_3, s3_2, s3_1, s3_0, s2_0, s1_0, pp[0][0]};

  product_t P_d;
  logic     valid_d;
  logic     valid_q;

  always_comb begin
    P_d     = P;
    valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      P_q     <= P_d;
      valid_q <= valid_d;
    end
  end

  assign p_valid = valid_q;
endmodule

// File: tb/tb_multiplier_4bit.sv
// Self-checking bench for multiplier_4bit: vector table, exhaustive sweep, registered-path scoreboard.
module tb_multiplier_4bit;
  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic [7:0] P_q;
  logic       p_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [7];

  multiplier_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .P       (P),
    .P_q     (P_q),
    .p_valid (p_valid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pop the product expected from the edge that just passed and compare P_q.
  task automatic check_reg(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, P_q=0x%0h", name, P_q);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, P_q}, {24'd0, e});
      check({name, "_valid"}, {31'd0, p_valid}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd9,  b: 4'd2,  p: 8'h12};
    vecs[3] = '{a: 4'd6,  b: 4'd4,  p: 8'h18};
    vecs[4] = '{a: 4'd0,  b: 4'd13, p: 8'h00};
    vecs[5] = '{a: 4'd1,  b: 4'd11, p: 8'h0B};
    vecs[6] = '{a: 4'd7,  b: 4'd1,  p: 8'h07};

    rst = 1'b1;
    A   = 4'd0;
    B   = 4'd0;
    #5;
    check("reset_P_q", {24'd0, P_q}, 32'd0);
    check("reset_valid", {31'd0, p_valid}, 32'd0);

    // Combinational path with reset held: registered outputs must stay cleared.
    for (int v = 0; v < 7; v++) begin
      A = vecs[v].a;
      B = vecs[v].b;
      #10;
      check($sformatf("table_P_%0d", v), {24'd0, P}, {24'd0, vecs[v].p});
      check($sformatf("table_P_q_%0d", v), {24'd0, P_q}, 32'd0);
      check($sformatf("table_valid_%0d", v), {31'd0, p_valid}, 32'd0);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #10;
        check($sformatf("sweep_%0dx%0d", a, b), {24'd0, P}, 32'(a * b));
      end
    end

    // Registered path after a mid-cycle release.
    @(negedge clk);
    rst = 1'b0;
    A   = 4'd15;
    B   = 4'd15;
    exp_q.push_back(8'hE1);
    @(negedge clk);
    check_reg("reg_first_load");
    A = 4'd3;
    B = 4'd5;
    exp_q.push_back(8'h0F);
    #1;
    check("reg_P_immediate", {24'd0, P}, 32'h0F);
    check("reg_P_q_holds", {24'd0, P_q}, 32'hE1);
    @(negedge clk);
    check_reg("reg_second_load");

    // Asynchronous assertion between edges.
    #5;
    rst = 1'b1;
    #1;
    check("async_P_q", {24'd0, P_q}, 32'd0);
    check("async_valid", {31'd0, p_valid}, 32'd0);
    check("async_P", {24'd0, P}, 32'h0F);

    // Release exactly at an edge: the flop sees reset still high on that edge.
    A = 4'd6;
    B = 4'd4;
    @(posedge clk);
    rst <= 1'b0;
    @(negedge clk);
    check("coinc_P_q", {24'd0, P_q}, 32'd0);
    check("coinc_valid", {31'd0, p_valid}, 32'd0);
    exp_q.push_back(8'h18);
    @(negedge clk);
    check_reg("coinc_next_load");

    // Back-to-back random operands through the register.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      A  = ra;
      B  = rb;
      exp_q.push_back(8'(ra * rb));
      @(negedge clk);
      check_reg($sformatf("stream_%0d", n));
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
